// File: rtl/sq_cbrt_unit_pkg.sv
// Shared definitions for the square plus cube-root unit: FSM states and
// the width/latency derivations used by RTL and integrators.
package sq_cbrt_unit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StMul,
        StCmp,
        StUpd,
        StSum,
        StDone
    } state_e;

    // Root width and cube-root iteration count: ceil(w/3).
    function automatic int unsigned calc_n(input int unsigned w);
        return (w + 2) / 3;
    endfunction

    // Cycles from the accepting edge to the edge that samples ready.
    function automatic int unsigned calc_latency(input int unsigned w);
        return calc_n(w) * (w + 4) + 2;
    endfunction

endpackage

// File: rtl/sq_cbrt_unit_seq_mult.sv
// Shift-add unsigned multiplier, W x W -> 2W. The start edge performs the
// first partial product, so done pulses W-1 edges later and p is final then.
module seq_mult #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = b[0] ? {{W{1'b0}}, a} : '0;
            mcand_d  = {{(W - 1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = CW'(W - 1);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            done_d   = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/sq_cbrt_unit.sv
// Computes y = a*a + floor(cbrt(b)) with two sequential multipliers and one
// shared W+2-bit adder/subtractor; fixed latency regardless of operands.
module sq_cbrt_unit
    import sq_cbrt_unit_pkg::*;
#(
    parameter int unsigned W = 16,
    localparam int unsigned N = calc_n(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           ready,
    output logic [2*W-1:0] y,
    output logic [N-1:0]   root
);

    localparam int unsigned SW = $clog2(3 * N);
    localparam logic [SW-1:0] SInit = SW'(3 * (N - 1));

    state_e         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [N-1:0]   r_q, r_d;
    logic [SW-1:0]  s_q, s_d;
    logic [W+1:0]   c_q, c_d;
    logic           c_big_q, c_big_d;
    logic           ge_q, ge_d;
    logic           upd_ph_q, upd_ph_d;
    logic [2*W-1:0] sq_q, sq_d;
    logic [2*W-1:0] y_q, y_d;
    logic [N-1:0]   root_q, root_d;

    logic           m0_start, m0_done, m1_start, m1_done;
    logic [2*W-1:0] p0, p1;
    logic [N-1:0]   r_dbl;

    // Shared adder/subtractor; for subtraction the top bit is the no-borrow flag.
    logic [W+1:0]   add_a, add_b;
    logic           add_sub, add_cin;
    logic [W+2:0]   add_res;

    assign r_dbl   = {r_q[N-2:0], 1'b0};
    assign add_res = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)}
                   + {{(W + 2){1'b0}}, add_cin};

    seq_mult #(
        .W (W)
    ) u_mult0 (
        .clk   (clk),
        .rst   (rst),
        .start (m0_start),
        .a     ({{(W - N){1'b0}}, r_dbl}),
        .b     ({{(W - N){1'b0}}, r_dbl[N-1:1], 1'b1}),
        .done  (m0_done),
        .p     (p0)
    );

    seq_mult #(
        .W (W)
    ) u_mult1 (
        .clk   (clk),
        .rst   (rst),
        .start (m1_start),
        .a     (a),
        .b     (a),
        .done  (m1_done),
        .p     (p1)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        r_d      = r_q;
        s_d      = s_q;
        c_d      = c_q;
        c_big_d  = c_big_q;
        ge_d     = ge_q;
        upd_ph_d = upd_ph_q;
        sq_d     = m1_done ? p1 : sq_q;
        y_d      = y_q;
        root_d   = root_q;
        add_a    = '0;
        add_b    = '0;
        add_sub  = 1'b0;
        add_cin  = 1'b0;
        m0_start = 1'b0;
        m1_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m1_start = 1'b1;
                    x_d      = b;
                    r_d      = '0;
                    s_d      = SInit;
                    state_d  = StPrep;
                end
            end
            StPrep: begin
                r_d      = r_dbl;
                m0_start = 1'b1;
                state_d  = StMul;
            end
            StMul: begin
                if (m0_done) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // c = 3p + 1; any product bits beyond the path width make c
                // unreachable for a W-bit remainder, so the digit is 0.
                add_a    = {p0[W:0], 1'b0};
                add_b    = p0[W+1:0];
                add_cin  = 1'b1;
                c_d      = add_res[W+1:0];
                c_big_d  = (|p0[2*W-1:W+1]) | add_res[W+2];
                upd_ph_d = 1'b0;
                state_d  = StUpd;
            end
            StUpd: begin
                add_sub = 1'b1;
                add_cin = 1'b1;
                if (!upd_ph_q) begin
                    add_a    = {2'b00, x_q >> s_q};
                    add_b    = c_q;
                    ge_d     = add_res[W+2] & ~c_big_q;
                    upd_ph_d = 1'b1;
                end else begin
                    // c<<s only matters when ge_q, and then it fits below x.
                    add_a = {2'b00, x_q};
                    add_b = c_q << s_q;
                    if (ge_q) begin
                        x_d = add_res[W-1:0];
                        r_d = {r_q[N-1:1], 1'b1};
                    end
                    if (s_q == '0) begin
                        state_d = StSum;
                    end else begin
                        s_d     = s_q - SW'(3);
                        state_d = StPrep;
                    end
                end
            end
            StSum: begin
                add_a   = {2'b00, sq_q[W-1:0]};
                add_b   = {{(W + 2 - N){1'b0}}, r_q};
                y_d     = {sq_q[2*W-1:W] + {{(W - 1){1'b0}}, add_res[W]}, add_res[W-1:0]};
                root_d  = r_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            r_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            c_big_q  <= 1'b0;
            ge_q     <= 1'b0;
            upd_ph_q <= 1'b0;
            sq_q     <= '0;
            y_q      <= '0;
            root_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            r_q      <= r_d;
            s_q      <= s_d;
            c_q      <= c_d;
            c_big_q  <= c_big_d;
            ge_q     <= ge_d;
            upd_ph_q <= upd_ph_d;
            sq_q     <= sq_d;
            y_q      <= y_d;
            root_q   <= root_d;
        end
    end

    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign ready = (state_q == StDone);
    assign y     = y_q;
    assign root  = root_q;

endmodule

// File: tb/tb_sq_cbrt_unit.sv
// Directed and randomized checks of sq_cbrt_unit at W=16 and W=8 against a
// plain-arithmetic reference (a*a plus largest r with r^3 <= b).
module tb_sq_cbrt_unit;

    logic        clk;
    logic        rst;
    logic        start16, busy16, ready16;
    logic [15:0] a16, b16;
    logic [31:0] y16;
    logic [5:0]  root16;
    logic        start8, busy8, ready8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;
    logic [2:0]  root8;

    int passed = 0;
    int total  = 0;

    sq_cbrt_unit #(.W(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .ready (ready16),
        .y     (y16),
        .root  (root16)
    );

    sq_cbrt_unit #(.W(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .ready (ready8),
        .y     (y8),
        .root  (root8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint icbrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input bit w8, input logic st, input logic [15:0] av,
                         input logic [15:0] bv);
        if (w8) begin
            start8 = st;
            a8     = av[7:0];
            b8     = bv[7:0];
        end else begin
            start16 = st;
            a16     = av;
            b16     = bv;
        end
    endtask

    // One operation; inputs are scrambled after acceptance, and optionally
    // extra starts are pulsed at cycles 10 and 50 while busy.
    task automatic run_op(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                          input bit pulses, input string tag);
        int          wd, nn, lim, lat, extra;
        logic [63:0] er, ey, yo, ro;
        wd  = w8 ? 8 : 16;
        nn  = (wd + 2) / 3;
        lim = nn * (wd + 4) + 2;
        er  = 64'(icbrt(longint'(bv)));
        ey  = 64'(av) * 64'(av) + er;
        lat = 0;
        yo  = '0;
        ro  = '0;
        @(negedge clk);
        drive(w8, 1'b1, av, bv);
        for (int c = 1; c <= 400 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({tag, "_busy_after_accept"}, 64'(w8 ? busy8 : busy16), 64'd1);
                drive(w8, 1'b0, 16'($urandom), 16'($urandom));
            end else if (pulses && (c == 10 || c == 50)) begin
                drive(w8, 1'b1, 16'($urandom), 16'($urandom));
            end else if (w8) begin
                start8 = 1'b0;
            end else begin
                start16 = 1'b0;
            end
            if (w8 ? ready8 : ready16) begin
                lat = c;
                yo  = w8 ? 64'(y8) : 64'(y16);
                ro  = w8 ? 64'(root8) : 64'(root16);
                check({tag, "_busy_at_ready"}, 64'(w8 ? busy8 : busy16), 64'd0);
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(lim));
        check({tag, "_root"}, ro, er);
        check({tag, "_y"}, yo, ey);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (w8 ? ready8 : ready16) extra++;
        end
        check({tag, "_single_ready"}, 64'(extra), 64'd0);
        check({tag, "_y_held"}, w8 ? 64'(y8) : 64'(y16), ey);
    endtask

    initial begin
        int extra;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy16), 64'd0);
        check("rst_ready", 64'(ready16), 64'd0);
        check("rst_y", 64'(y16), 64'd0);
        check("rst_root", 64'(root16), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        rst = 1'b0;

        run_op(1'b0, 16'd3, 16'd27, 1'b0, "a3_b27");
        run_op(1'b0, 16'd0, 16'd0, 1'b0, "zero");
        run_op(1'b0, 16'd5, 16'd26, 1'b0, "below_cube");
        run_op(1'b0, 16'hffff, 16'hffff, 1'b0, "full_scale");
        run_op(1'b0, 16'd100, 16'd1000, 1'b1, "ignored_starts");

        // Reset mid-operation: abort, clear outputs, no ready afterwards.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd1234, 16'd5000);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start16 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy16), 64'd0);
        check("abort_y", 64'(y16), 64'd0);
        check("abort_root", 64'(root16), 64'd0);
        extra = 0;
        repeat (150) begin
            @(negedge clk);
            if (ready16) extra++;
        end
        check("abort_no_ready", 64'(extra), 64'd0);
        run_op(1'b0, 16'd1234, 16'd5000, 1'b0, "after_abort");

        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'b0, "rand16");
        end

        run_op(1'b1, 16'd255, 16'd255, 1'b0, "w8_full");
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 16'($urandom_range(255)), 16'($urandom_range(255)), 1'b0, "rand8");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sq_cbrt_unit.md
SQ_CBRT_UNIT -- requirements
Module: sq_cbrt_unit

Interface
REQ-001 Parameter: W, default 16, operand width in bits; legal range 6..32.
REQ-002 Derived constant: N = ceil(W/3), root width and cube-root iteration count.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request pulse; accepted only when busy=0.
REQ-006 Port: a  input  W  unsigned operand to be squared.
REQ-007 Port: b  input  W  unsigned operand whose integer cube root is taken.
REQ-008 Port: busy  output  1  high from the cycle after acceptance until the cycle ready pulses.
REQ-009 Port: ready  output  1  one-cycle pulse; y and root are valid on that cycle.
REQ-010 Port: y  output  2W  result a*a + floor(cbrt(b)).
REQ-011 Port: root  output  N  floor(cbrt(b)), exposed for debug and verification.

Function
REQ-012 On acceptance (start=1 and busy=0), a and b SHALL be latched; later changes on a or b SHALL have no effect on the result.
REQ-013 start while busy=1 SHALL be ignored: no queuing, no restart, no error.
REQ-014 Arithmetic resources: exactly two seq_mult instances and one shared W+2-bit adder/subtractor; no other multipliers.
REQ-015 Squaring: at acceptance, mult1 starts a*a; its 2W-bit product SHALL be held until the final sum.
REQ-016 Cube root: digit-by-digit method. Start values: x=b, r=0, s=3(N-1). Each iteration: r=2r; c=3*r*(r+1)+1; if (x>>s)>=c then x=x-(c<<s) and r=r+1; s=s-3.
REQ-017 States SHALL be IDLE, PREP, MUL, CMP, UPD, SUM, DONE.
REQ-018 IDLE->PREP on acceptance. PREP (1 cycle): r=2r; start mult0 on r*(r+1).
REQ-019 MUL (W cycles): waits for mult0 done. CMP (1 cycle): c=(p<<1)+p+1 via the adder.
REQ-020 UPD (2 cycles): conditional subtract and increment. Then PREP if iterations remain, else SUM.
REQ-021 SUM (1 cycle): y=a*a+root via the adder. DONE (1 cycle): ready=1, busy drops, return to IDLE.
REQ-022 Latency from the accepting edge to the ready pulse SHALL be exactly N*(W+4)+2 cycles, independent of operand values (W=16: 122).
REQ-023 y width 2W SHALL never overflow: (2^W-1)^2 + 2^N-1 < 2^(2W) for all legal W.
REQ-024 The internal compare/subtract path SHALL be W+2 bits wide so that c<<s never truncates before comparison.
REQ-025 y and root SHALL hold their last values until the next ready pulse.
REQ-026 A new start is accepted in the cycle after DONE, so back-to-back operations run with one idle cycle between them.

Reset
REQ-027 While rst=1: state=IDLE, busy=0, ready=0, y=0, root=0, all internal registers and multiplier state cleared.
REQ-028 rst asserted mid-operation SHALL abort the operation within the same edge; no ready pulse SHALL follow.
REQ-029 rst has priority over start on the same edge.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the N derivation function and the latency function N*(W+4)+2.
REQ-031 Sub-module seq_mult (parameter W): shift-add unsigned multiplier, W x W -> 2W, start/done handshake, fixed W-cycle latency, synchronous active-high rst.
REQ-032 Expected size: 120-400 RTL lines for sq_cbrt_unit plus seq_mult.

Verification
REQ-033 W=16: a=3, b=27 -> ready exactly 122 cycles after accept; y=12, root=3.
REQ-034 W=16: a=0, b=0 -> y=0, root=0; a=5, b=26 -> y=27, root=2 (boundary just below a cube).
REQ-035 W=16: a=65535, b=65535 -> root=40, y=4294836265 (full scale, no overflow).
REQ-036 W=16: start pulsed again at cycles 10 and 50 of a busy operation with different a/b -> ignored; first result unchanged; exactly one ready pulse.
REQ-037 W=16: rst for 1 cycle at cycle 60 of an operation -> no ready; a fresh start afterwards gives the correct result with latency 122.
REQ-038 W=8: a=255, b=255 -> root=6, y=65031, latency 38 cycles.
